// File: rtl/flip_decoder_rx_if.sv
// flip_decoder_rx_if: valid/ready links around the bus-invert decoder.
// Upstream side carries the encoded payload plus invert flag; downstream side
// carries the restored word. The slave modport is the decoder's view and the
// master modport is the view of whatever drives and consumes it.
interface flip_decoder_rx_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_inv,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output in_inv,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/flip_decoder_rx.sv
// flip_decoder_rx: receive side of the bus-invert (data flipping) scheme.
// Restores each encoded word (payload XOR invert flag), queues it in a
// 2-entry FIFO toward the consumer and keeps word/inversion statistics.
// Optional macro FLIP_CHECK_EN adds a sticky check that the sender's invert
// decision matches the Hamming distance against the previous bus value.
module flip_decoder_rx #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  flip_decoder_rx_if.slave     bus,
  input  logic                 clr_counts,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     inv_count,
  output logic                 chk_err
);

  // FIFO occupancy doubles as the control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_t             occ_reg, occ_next;
  logic [N-1:0]     head_reg, head_next;
  logic [N-1:0]     tail_reg, tail_next;
  logic [N-1:0]     decoded;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] word_count_reg, word_count_next;
  logic [CNT_W-1:0] inv_count_reg, inv_count_next;

  // Per-bit restore of the original word from the coded payload.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_decode
      assign decoded[gi] = bus.in_data[gi] ^ bus.in_inv;
    end
  endgenerate

  // Ready and valid come straight from registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign bus.in_ready  = (occ_reg != OCC_TWO);
  assign bus.out_valid = (occ_reg != OCC_EMPTY);
  assign bus.out_data  = head_reg;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Occupancy and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_reg  <= OCC_EMPTY;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      occ_reg  <= occ_next;
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // Next occupancy and data movement. The head register is the output, so
  // it keeps its last value when the FIFO drains.
  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    case (occ_reg)
      OCC_EMPTY: begin
        if (push) begin
          head_next = decoded;
          occ_next  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_next = decoded;
            occ_next  = OCC_TWO;
          end
          2'b01: begin
            occ_next = OCC_EMPTY;
          end
          2'b11: begin
            // Head leaves and the new word takes its place.
            head_next = decoded;
          end
          default: begin
            occ_next = OCC_ONE;
          end
        endcase
      end
      OCC_TWO: begin
        // No push possible here; a pop promotes the tail.
        if (pop) begin
          head_next = tail_reg;
          occ_next  = OCC_ONE;
        end
      end
      default: begin
        occ_next = OCC_EMPTY;
      end
    endcase
  end

  // Saturating statistics; a clear in the same cycle beats a push.
  always_comb begin
    word_count_next = word_count_reg;
    inv_count_next  = inv_count_reg;
    if (clr_counts) begin
      word_count_next = '0;
      inv_count_next  = '0;
    end else if (push) begin
      if (word_count_reg != CNT_MAX) begin
        word_count_next = word_count_reg + 1'b1;
      end
      if (bus.in_inv && (inv_count_reg != CNT_MAX)) begin
        inv_count_next = inv_count_reg + 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count_reg <= '0;
      inv_count_reg  <= '0;
    end else begin
      word_count_reg <= word_count_next;
      inv_count_reg  <= inv_count_next;
    end
  end

  assign word_count = word_count_reg;
  assign inv_count  = inv_count_reg;

`ifdef FLIP_CHECK_EN
  // Wide enough to hold a distance of N.
  localparam int HW = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [HW-1:0] HALF = HW'(N / 2);

  logic [N-1:0]  prev_bus_reg;
  logic [N-1:0]  diff;
  logic [HW-1:0] hdist;
  logic          violation;
  logic          chk_err_reg;

  // Bits that would toggle between the previous bus value and the original
  // word had it been sent uninverted.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_diff
      assign diff[gi] = prev_bus_reg[gi] ^ decoded[gi];
    end
  endgenerate

  // Hamming distance as a popcount of the difference vector.
  always_comb begin
    hdist = '0;
    for (int i = 0; i < N; i++) begin
      hdist = hdist + HW'(diff[i]);
    end
  end

  // The sender should invert exactly when more than half the bits would
  // toggle; any other choice is flagged.
  assign violation = bus.in_inv ? (hdist <= HALF) : (hdist > HALF);

  // Previous raw bus value and sticky error flag; clr_counts leaves prev_bus
  // alone but clears the flag with priority over a new violation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_bus_reg <= '0;
      chk_err_reg  <= 1'b0;
    end else begin
      if (push) begin
        prev_bus_reg <= bus.in_data;
      end
      if (clr_counts) begin
        chk_err_reg <= 1'b0;
      end else if (push && violation) begin
        chk_err_reg <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_reg;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_flip_decoder_rx.sv
// tb_flip_decoder_rx: randomized and directed stimulus for flip_decoder_rx
// against a queue-based reference model. Two instances run in lockstep: one
// with 16-bit counters and one with 4-bit counters for saturation.
module tb_flip_decoder_rx;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_counts = 1'b0;
  logic [15:0] wc_a, ic_a;
  logic [3:0]  wc_b, ic_b;
  logic        err_a, err_b;

  flip_decoder_rx_if #(.N(N)) bus_a ();
  flip_decoder_rx_if #(.N(N)) bus_b ();

  flip_decoder_rx #(.N(N), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a),
    .clr_counts (clr_counts),
    .word_count (wc_a),
    .inv_count  (ic_a),
    .chk_err    (err_a)
  );

  flip_decoder_rx #(.N(N), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b),
    .clr_counts (clr_counts),
    .word_count (wc_b),
    .inv_count  (ic_b),
    .chk_err    (err_b)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [15:0] q[$];
  logic [15:0] last_out;
  int          wc, ic, wc4, ic4;
  logic        err_m;
  logic [15:0] prev_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_out = '0;
    wc = 0; ic = 0; wc4 = 0; ic4 = 0;
    err_m = 1'b0;
    prev_m = '0;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : last_out;
    check_val("in_ready",    32'(bus_a.in_ready),  32'(q.size() < 2));
    check_val("out_valid",   32'(bus_a.out_valid), 32'(q.size() > 0));
    check_val("out_data",    32'(bus_a.out_data),  32'(exp_data));
    check_val("word_count",  32'(wc_a),            32'(wc));
    check_val("inv_count",   32'(ic_a),            32'(ic));
    check_val("chk_err",     32'(err_a),           32'(err_m));
    check_val("in_ready4",   32'(bus_b.in_ready),  32'(q.size() < 2));
    check_val("out_data4",   32'(bus_b.out_data),  32'(exp_data));
    check_val("word_count4", 32'(wc_b),            32'(wc4));
    check_val("inv_count4",  32'(ic_b),            32'(ic4));
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic i,
                       input logic r, input logic c);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_inv = i; bus_a.out_ready = r;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_inv = i; bus_b.out_ready = r;
    clr_counts = c;
  endtask

  // One clock of traffic: drive, advance the model at the edge, then check
  // on the falling edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic i,
                       input logic r, input logic c);
    logic        push, pop, viol;
    logic [15:0] dec;
    int          h;
    drive(v, d, i, r, c);
    push = v && (q.size() < 2);
    pop  = r && (q.size() > 0);
    dec  = i ? ~d : d;
    h    = $countones(prev_m ^ dec);
    viol = i ? (h <= N / 2) : (h > N / 2);
    @(posedge clk);
    if (pop) last_out = q.pop_front();
    if (push) q.push_back(dec);
    if (c) begin
      wc = 0; ic = 0; wc4 = 0; ic4 = 0;
      err_m = 1'b0;
    end else if (push) begin
      if (wc < 65535) wc++;
      if (wc4 < 15) wc4++;
      if (i && ic < 65535) ic++;
      if (i && ic4 < 15) ic4++;
`ifdef FLIP_CHECK_EN
      if (viol) err_m = 1'b1;
`endif
    end
    if (push) prev_m = d;
    @(negedge clk);
    check_outputs();
    $display("cyc v=%0b d=%h inv=%0b rdy=%0b clr=%0b push=%0b pop=%0b out=%h occ=%0d wc=%0d ic=%0d err=%0b",
             v, d, i, r, c, push, pop, bus_a.out_data, q.size(), wc_a, ic_a, err_a);
  endtask

  // Asynchronous reset: effect is checked before any clock edge arrives.
  task automatic do_reset(input int cycles);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs();
    $display("reset released after %0d cycles", cycles);
  endtask

  initial begin
    logic [15:0] rd;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Detector case: all bits toggle but not inverted.
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Basic decode with streaming consumer.
    cycle(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'hFF00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Backpressure: A, B fill the FIFO, C stalls until space opens.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Clear wins over a same-cycle inverted push; the word is still stored.
    cycle(1'b1, 16'h1357, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Saturation of the 4-bit counters.
    do_reset(1);
    repeat (17) begin
      rd = 16'($urandom);
      cycle(1'b1, rd, 1'b1, 1'b1, 1'b0);
    end

    // Inverted all-zero payload after reset is a legitimate inversion.
    do_reset(1);
    cycle(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional clears and mid-run resets.
    for (int k = 0; k < 800; k++) begin
      if (k % 200 == 199) begin
        do_reset(1);
      end else begin
        rd = 16'($urandom);
        cycle($urandom_range(0, 3) != 0, rd, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
